// File: rtl/ise_pkg.sv
// ise_pkg: shared types and constants for the image sorting engine control.
//   state_e      - controller FSM states
//   COLOR_*      - classifier colour codes
//   tbl_entry_t  - result table entry {colour, image index}
//   pix_per_img  - pixels per image for a given edge length
package ise_pkg;

   localparam int unsigned TBL_IDX_W = 5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CLS,
      S_WAIT,
      S_OUT,
      S_DONE
   } state_e;

   localparam logic [1:0] COLOR_R = 2'd0;
   localparam logic [1:0] COLOR_G = 2'd1;
   localparam logic [1:0] COLOR_B = 2'd2;

   typedef struct packed {
      logic [1:0]           color;
      logic [TBL_IDX_W-1:0] index;
   } tbl_entry_t;

   function automatic int unsigned pix_per_img(input int unsigned size);
      return size * size;
   endfunction

endpackage

// File: rtl/ise_out_sched.sv
// ise_out_sched: output scheduler. On a go pulse it scans the result table
// colour by colour (outer loop c = R,G,B; inner loop e = 0..IMAGE_NUM-1),
// one entry per cycle, and emits a registered strobe for every matching entry.
//   clk, reset        - clock, synchronous active-low reset
//   go                - start a scan (one-cycle pulse)
//   tbl, tbl_valid    - result table contents and entry valid bits
//   done              - high during the last scan cycle
//   out_valid, color_index, image_out_index - registered result strobe
module ise_out_sched
   import ise_pkg::*;
#(
   parameter int unsigned IMAGE_NUM = 32,
   parameter int unsigned IDX_W     = 5
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             go,
   input  tbl_entry_t [IMAGE_NUM-1:0]       tbl,
   input  logic       [IMAGE_NUM-1:0]       tbl_valid,
   output logic                             done,
   output logic                             out_valid,
   output logic       [1:0]                 color_index,
   output logic       [IDX_W-1:0]           image_out_index
);

   localparam int unsigned EW = (IMAGE_NUM > 1) ? $clog2(IMAGE_NUM) : 1;

   logic             active_q, active_d;
   logic [1:0]       c_q, c_d;
   logic [EW-1:0]    e_q, e_d;
   logic             ov_q, ov_d;
   logic [1:0]       col_q, col_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   tbl_entry_t       cur;
   logic             e_last;

   always_comb begin
      active_d = active_q;
      c_d      = c_q;
      e_d      = e_q;
      ov_d     = 1'b0;
      col_d    = col_q;
      idx_d    = idx_q;
      cur      = tbl[e_q];
      e_last   = (e_q == EW'(IMAGE_NUM - 1));
      done     = active_q && e_last && (c_q == COLOR_B);

      if (go) begin
         active_d = 1'b1;
         c_d      = COLOR_R;
         e_d      = '0;
      end else if (active_q) begin
         if (tbl_valid[e_q] && (cur.color == c_q)) begin
            ov_d  = 1'b1;
            col_d = c_q;
            idx_d = IDX_W'(cur.index);
         end
         if (e_last) begin
            e_d = '0;
            c_d = c_q + 2'd1;
            if (c_q == COLOR_B) begin
               active_d = 1'b0;
            end
         end else begin
            e_d = e_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         active_q <= 1'b0;
         c_q      <= COLOR_R;
         e_q      <= '0;
         ov_q     <= 1'b0;
         col_q    <= COLOR_R;
         idx_q    <= '0;
      end else begin
         active_q <= active_d;
         c_q      <= c_d;
         e_q      <= e_d;
         ov_q     <= ov_d;
         col_q    <= col_d;
         idx_q    <= idx_d;
      end
   end

   assign out_valid       = ov_q;
   assign color_index     = col_q;
   assign image_out_index = idx_q;

endmodule

// File: rtl/ise_ctrl.sv
// ise_ctrl: control and scheduling block of the image sorting engine.
// Counts pixels per image, drives the accumulator enables, triggers the
// classifier at each image boundary, records {colour, index} per image and,
// after IMAGE_NUM images, emits the results grouped by colour.
//   clk, reset              - clock, synchronous active-low reset
//   pix_valid, image_in_index, busy - pixel stream handshake
//   acc_en, acc_first       - accumulator enable / load-instead-of-add
//   cls_start, cls_done, cls_color - classifier handshake
//   out_valid, color_index, image_out_index - result stream
// Optional: define ISE_PERF_CNT_EN to add perf_cycles[31:0], a saturating
// cycle counter from the first accepted pixel of image 0 to entry into DONE.
module ise_ctrl
   import ise_pkg::*;
#(
   parameter int unsigned IMAGE_NUM  = 32,
   parameter int unsigned IMAGE_SIZE = 128,
   parameter int unsigned IDX_W      = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pix_valid,
   input  logic [IDX_W-1:0] image_in_index,
   output logic             busy,
   output logic             acc_en,
   output logic             acc_first,
   output logic             cls_start,
   input  logic             cls_done,
   input  logic [1:0]       cls_color,
   output logic             out_valid,
   output logic [1:0]       color_index,
   output logic [IDX_W-1:0] image_out_index
`ifdef ISE_PERF_CNT_EN
   ,
   output logic [31:0]      perf_cycles
`endif
);

   localparam int unsigned PIX = pix_per_img(IMAGE_SIZE);
   localparam int unsigned PCW = $clog2(PIX + 1);
   localparam int unsigned EW  = (IMAGE_NUM > 1) ? $clog2(IMAGE_NUM) : 1;

   state_e                      state_q, state_d;
   logic [PCW-1:0]              pix_cnt_q, pix_cnt_d;
   logic [EW-1:0]               img_cnt_q, img_cnt_d;
   logic [IDX_W-1:0]            lat_idx_q, lat_idx_d;
   logic                        busy_q, busy_d;
   tbl_entry_t [IMAGE_NUM-1:0]  tbl_q, tbl_d;
   logic [IMAGE_NUM-1:0]        tbl_valid_q, tbl_valid_d;
   logic                        accept;
   logic                        sched_go;
   logic                        sched_done;

   always_comb begin
      state_d     = state_q;
      pix_cnt_d   = pix_cnt_q;
      img_cnt_d   = img_cnt_q;
      lat_idx_d   = lat_idx_q;
      busy_d      = busy_q;
      tbl_d       = tbl_q;
      tbl_valid_d = tbl_valid_q;
      acc_en      = 1'b0;
      acc_first   = 1'b0;
      cls_start   = 1'b0;
      sched_go    = 1'b0;
      // Combinational enables are gated by reset so they stay low while it is held.
      accept      = reset && pix_valid && !busy_q &&
                    ((state_q == S_IDLE) || (state_q == S_LOAD));

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               acc_en    = 1'b1;
               acc_first = 1'b1;
               lat_idx_d = image_in_index;
               pix_cnt_d = PCW'(1);
               if (PIX == 1) begin
                  state_d = S_CLS;
                  busy_d  = 1'b1;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            if (accept) begin
               acc_en = 1'b1;
               if (pix_cnt_q == PCW'(PIX - 1)) begin
                  state_d   = S_CLS;
                  busy_d    = 1'b1;
                  pix_cnt_d = '0;
               end else begin
                  pix_cnt_d = pix_cnt_q + 1'b1;
               end
            end
         end
         S_CLS: begin
            cls_start = reset;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            if (cls_done) begin
               tbl_d[img_cnt_q].color = (cls_color == 2'd3) ? COLOR_B : cls_color;
               tbl_d[img_cnt_q].index = TBL_IDX_W'(lat_idx_q);
               tbl_valid_d[img_cnt_q] = 1'b1;
               img_cnt_d              = img_cnt_q + 1'b1;
               if (img_cnt_q == EW'(IMAGE_NUM - 1)) begin
                  state_d  = S_OUT;
                  sched_go = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
               end
            end
         end
         S_OUT: begin
            busy_d = 1'b1;
            if (sched_done) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            busy_d = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         pix_cnt_q   <= '0;
         img_cnt_q   <= '0;
         lat_idx_q   <= '0;
         busy_q      <= 1'b0;
         tbl_q       <= '0;
         tbl_valid_q <= '0;
      end else begin
         state_q     <= state_d;
         pix_cnt_q   <= pix_cnt_d;
         img_cnt_q   <= img_cnt_d;
         lat_idx_q   <= lat_idx_d;
         busy_q      <= busy_d;
         tbl_q       <= tbl_d;
         tbl_valid_q <= tbl_valid_d;
      end
   end

   assign busy = busy_q;

   ise_out_sched #(
      .IMAGE_NUM (IMAGE_NUM),
      .IDX_W     (IDX_W)
   ) u_out_sched (
      .clk             (clk),
      .reset           (reset),
      .go              (sched_go),
      .tbl             (tbl_q),
      .tbl_valid       (tbl_valid_q),
      .done            (sched_done),
      .out_valid       (out_valid),
      .color_index     (color_index),
      .image_out_index (image_out_index)
   );

`ifdef ISE_PERF_CNT_EN
   logic        perf_run_q, perf_run_d;
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_run_d = perf_run_q;
      perf_d     = perf_q;
      if (perf_run_q && (perf_q != '1)) begin
         perf_d = perf_q + 32'd1;
      end
      if (accept && (state_q == S_IDLE) && (img_cnt_q == '0) && !perf_run_q) begin
         perf_run_d = 1'b1;
         perf_d     = 32'd1;
      end
      if ((state_d == S_DONE) && (state_q != S_DONE)) begin
         perf_run_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         perf_run_q <= 1'b0;
         perf_q     <= '0;
      end else begin
         perf_run_q <= perf_run_d;
         perf_q     <= perf_d;
      end
   end

   assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_ise_ctrl.sv
// tb_ise_ctrl: directed bench for ise_ctrl with IMAGE_NUM=4, IMAGE_SIZE=2.
// A per-cycle vector table covers reset, pixel acceptance, classifier
// handshake and mid-image reset; two hand-written runs cover the output
// scheduler ordering and timing, including the colour-3 clamp.
module tb_ise_ctrl;

   localparam int unsigned N = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       pix_valid = 1'b0;
   logic [4:0] image_in_index = '0;
   logic       cls_done = 1'b0;
   logic [1:0] cls_color = '0;
   logic       busy, acc_en, acc_first, cls_start, out_valid;
   logic [1:0] color_index;
   logic [4:0] image_out_index;
`ifdef ISE_PERF_CNT_EN
   logic [31:0] perf_cycles;
`endif

   ise_ctrl #(
      .IMAGE_NUM  (N),
      .IMAGE_SIZE (2),
      .IDX_W      (5)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .pix_valid       (pix_valid),
      .image_in_index  (image_in_index),
      .busy            (busy),
      .acc_en          (acc_en),
      .acc_first       (acc_first),
      .cls_start       (cls_start),
      .cls_done        (cls_done),
      .cls_color       (cls_color),
      .out_valid       (out_valid),
      .color_index     (color_index),
      .image_out_index (image_out_index)
`ifdef ISE_PERF_CNT_EN
      ,
      .perf_cycles     (perf_cycles)
`endif
   );

   always #5 clk = ~clk;

   int unsigned n_run = 0;
   int unsigned n_fail = 0;

   // exp = {busy, acc_en, acc_first, cls_start, out_valid}
   typedef struct {
      logic       rst;
      logic       pv;
      logic [4:0] idx;
      logic       done;
      logic [1:0] col;
      logic [4:0] exp;
   } vec_t;

   vec_t vecs [28];

   logic [4:0] img_idx [N];
   logic [1:0] img_col [N];
   logic [1:0] exp_c   [N];
   logic [4:0] exp_i   [N];
   int         exp_t   [N];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rst, input logic pv, input logic [4:0] idx,
                               input logic done, input logic [1:0] col, input logic [4:0] exp);
      vec_t v;
      v.rst = rst; v.pv = pv; v.idx = idx; v.done = done; v.col = col; v.exp = exp;
      return v;
   endfunction

   task automatic run_images(input string tag);
      int          ns;
      logic [1:0]  got_c [N];
      logic [4:0]  got_i [N];
      int          got_t [N];
      @(posedge clk); #1;
      reset = 1'b0; pix_valid = 1'b0; cls_done = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      for (int img = 0; img < int'(N); img++) begin
         for (int p = 0; p < 4; p++) begin
            pix_valid      = 1'b1;
            image_in_index = img_idx[img];
            @(posedge clk); #1;
         end
         pix_valid = 1'b0;
         @(negedge clk);
         check($sformatf("%s_cls_start%0d", tag, img), 32'(cls_start), 32'd1);
         @(posedge clk); #1;
         cls_done  = 1'b1;
         cls_color = img_col[img];
         @(posedge clk); #1;
         cls_done = 1'b0;
      end
      ns = 0;
      for (int t = 0; t < 16; t++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            if (ns < int'(N)) begin
               got_c[ns] = color_index;
               got_i[ns] = image_out_index;
               got_t[ns] = t;
            end
            ns++;
         end
      end
      check($sformatf("%s_strobe_count", tag), 32'(ns), 32'(N));
      for (int k = 0; k < int'(N); k++) begin
         if (k < ns) begin
            check($sformatf("%s_strobe%0d_{c,i,t}", tag, k),
                  {22'd0, got_c[k], got_i[k], 3'd0}  + 32'(got_t[k]),
                  {22'd0, exp_c[k], exp_i[k], 3'd0}  + 32'(exp_t[k]));
         end
      end
      @(negedge clk);
      check($sformatf("%s_done_busy_ov", tag), 32'({busy, out_valid}), 32'b10);
`ifdef ISE_PERF_CNT_EN
      begin
         logic [31:0] p1;
         p1 = perf_cycles;
         check($sformatf("%s_perf_nonzero", tag), 32'(p1 != 32'd0), 32'd1);
         repeat (3) @(negedge clk);
         check($sformatf("%s_perf_frozen", tag), perf_cycles, p1);
      end
`endif
   endtask

   initial begin
      //            rst pv idx   dn col  busy acc first cs ov
      vecs[0]  = mk(0, 1, 5'd0, 0, 2'd0, 5'b00000);
      vecs[1]  = mk(0, 1, 5'd0, 0, 2'd0, 5'b00000);
      vecs[2]  = mk(1, 1, 5'd7, 0, 2'd0, 5'b01100);
      vecs[3]  = mk(1, 1, 5'd7, 0, 2'd0, 5'b01000);
      vecs[4]  = mk(1, 0, 5'd7, 0, 2'd0, 5'b00000);
      vecs[5]  = mk(1, 1, 5'd7, 0, 2'd0, 5'b01000);
      vecs[6]  = mk(1, 1, 5'd7, 0, 2'd0, 5'b01000);
      vecs[7]  = mk(1, 1, 5'd7, 0, 2'd0, 5'b10010);
      vecs[8]  = mk(1, 1, 5'd7, 0, 2'd0, 5'b10000);
      vecs[9]  = mk(1, 1, 5'd7, 0, 2'd0, 5'b10000);
      vecs[10] = mk(1, 1, 5'd7, 1, 2'd1, 5'b10000);
      vecs[11] = mk(1, 0, 5'd7, 1, 2'd1, 5'b00000);
      vecs[12] = mk(1, 1, 5'd9, 0, 2'd0, 5'b01100);
      vecs[13] = mk(1, 1, 5'd9, 0, 2'd0, 5'b01000);
      vecs[14] = mk(1, 1, 5'd9, 0, 2'd0, 5'b01000);
      vecs[15] = mk(1, 1, 5'd9, 0, 2'd0, 5'b01000);
      vecs[16] = mk(1, 0, 5'd9, 0, 2'd0, 5'b10010);
      vecs[17] = mk(1, 0, 5'd9, 1, 2'd2, 5'b10000);
      vecs[18] = mk(1, 1, 5'd4, 0, 2'd0, 5'b01100);
      vecs[19] = mk(1, 1, 5'd4, 0, 2'd0, 5'b01000);
      vecs[20] = mk(0, 1, 5'd4, 0, 2'd0, 5'b00000);
      vecs[21] = mk(1, 1, 5'd6, 0, 2'd0, 5'b01100);
      vecs[22] = mk(1, 1, 5'd6, 0, 2'd0, 5'b01000);
      vecs[23] = mk(1, 1, 5'd6, 0, 2'd0, 5'b01000);
      vecs[24] = mk(1, 1, 5'd6, 0, 2'd0, 5'b01000);
      vecs[25] = mk(1, 1, 5'd6, 0, 2'd0, 5'b10010);
      vecs[26] = mk(1, 1, 5'd6, 1, 2'd1, 5'b10000);
      vecs[27] = mk(1, 0, 5'd6, 0, 2'd0, 5'b00000);

      for (int i = 0; i < 28; i++) begin
         reset          = vecs[i].rst;
         pix_valid      = vecs[i].pv;
         image_in_index = vecs[i].idx;
         cls_done       = vecs[i].done;
         cls_color      = vecs[i].col;
         @(negedge clk);
         check($sformatf("vec%0d_{busy,acc,first,cs,ov}", i),
               32'({busy, acc_en, acc_first, cls_start, out_valid}), 32'(vecs[i].exp));
         @(posedge clk); #1;
      end

      // Colours [2,0,1,0] on indices [3,1,2,0]; scan (c,e) at OUT cycle
      // c*4+e, strobe visible one cycle later.
      img_idx = '{5'd3, 5'd1, 5'd2, 5'd0};
      img_col = '{2'd2, 2'd0, 2'd1, 2'd0};
      exp_c   = '{2'd0, 2'd0, 2'd1, 2'd2};
      exp_i   = '{5'd1, 5'd0, 5'd2, 5'd3};
      exp_t   = '{2, 4, 7, 9};
      run_images("runB");

      // Colour 3 on image index 5 lands in the blue group.
      img_idx = '{5'd5, 5'd1, 5'd2, 5'd0};
      img_col = '{2'd3, 2'd0, 2'd1, 2'd0};
      exp_c   = '{2'd0, 2'd0, 2'd1, 2'd2};
      exp_i   = '{5'd1, 5'd0, 5'd2, 5'd5};
      exp_t   = '{2, 4, 7, 9};
      run_images("runC");

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
